tdc_thermo_decoder: RTL and testbench

//  Read side of the TDC carry-chain delay line. Samples the N-tap thermometer code each clk and waits for an armed

---
 rtl/tdc_pkg.sv | 16 +
 rtl/tdc_popcount.sv | 42 ++++
 rtl/tdc_thermo_decoder.sv | 109 ++++++++++
 tb/tb_tdc_thermo_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC thermometer read side.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ENCODE = 2'd2,
    VALID  = 2'd3
  } tdc_state_e;

  // Result width able to hold every tap count 0..n without wrapping.
  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Combinational bubble corrector and tap counter for one frozen thermometer code.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]      tap,
  output logic [cw(N)-1:0]  code,
  output logic              all_ones
);

  localparam int CW = cw(N);

  // ext[i+1] = tap[i]; the ends act as virtual taps: before the chain is
  // always set, past the chain is always clear.
  logic [N+1:0] ext;
  logic [N-1:0] corr;

  assign ext = {1'b0, tap, 1'b1};

  // Three-tap majority vote removes isolated bubbles and stray bits.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_maj
      assign corr[gi] = (ext[gi]     & ext[gi + 1]) |
                        (ext[gi]     & ext[gi + 2]) |
                        (ext[gi + 1] & ext[gi + 2]);
    end
  endgenerate

  // Count corrected taps; the sum is written serially and left to
  // synthesis to rebalance.
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      code = code + CW'(corr[i]);
    end
  end

  assign all_ones = &corr;

endmodule

// File: rtl/tdc_thermo_decoder.sv
// Samples the delay-line taps, waits for an armed hit (or timeout), and
// presents the bubble-corrected tap count on a valid/ready interface.
module tdc_thermo_decoder
  import tdc_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255,
  localparam int CW     = cw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  dl_tap,
  input  logic          arm,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_code,
  output logic          res_ovf,
  output logic          res_unf
);

  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  tdc_state_e     state, state_next;
  logic [N-1:0]   s1, s2;
  logic [N-1:0]   hit;
  logic [TW-1:0]  timer;
  logic           unf_flag;
  logic [CW-1:0]  pop_code;
  logic           pop_all;

  // Two-flop synchroniser on the asynchronous tap vector; only s2 is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= dl_tap;
      s2 <= s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; arm is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (s2[0] || (timer == TIMER_LAST)) state_next = ENCODE;
      ENCODE:  state_next = VALID;
      VALID:   if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hit capture, timeout counting and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit      <= '0;
      timer    <= '0;
      unf_flag <= 1'b0;
      res_code <= '0;
      res_ovf  <= 1'b0;
      res_unf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            timer    <= '0;
            unf_flag <= 1'b0;
          end
        end
        ARMED: begin
          if (s2[0]) begin
            hit      <= s2;
            unf_flag <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            hit      <= '0;
            unf_flag <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ENCODE: begin
          res_code <= pop_code;
          res_ovf  <= pop_all;
          res_unf  <= unf_flag & ~pop_all;
        end
        default: ;
      endcase
    end
  end

  tdc_popcount #(.N(N)) u_popcount (
    .tap      (hit),
    .code     (pop_code),
    .all_ones (pop_all)
  );

  assign busy      = (state != IDLE);
  assign res_valid = (state == VALID);

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Scoreboard bench for tdc_thermo_decoder: stimulus pushes expected results,
// a monitor pops and compares on every accepted result.
module tb_tdc_thermo_decoder;

  localparam int N       = 64;
  localparam int TIMEOUT = 4;
  localparam int CW      = $clog2(N + 1);

  typedef struct {
    int code;
    bit ovf;
    bit unf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  dl_tap;
  logic          arm;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_code;
  logic          res_ovf;
  logic          res_unf;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_bad;

  tdc_thermo_decoder #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dl_tap    (dl_tap),
    .arm       (arm),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_code  (res_code),
    .res_ovf   (res_ovf),
    .res_unf   (res_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted result with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("res_code", 64'(res_code), 64'(mon_e.code));
        check("res_ovf",  64'(res_ovf),  64'(mon_e.ovf));
        check("res_unf",  64'(res_unf),  64'(mon_e.unf));
        $display("result code=%0d ovf=%0d unf=%0d", res_code, res_ovf, res_unf);
      end
    end
  end

  // One measurement: settle taps, arm, wait for valid, optional stall, accept.
  task automatic measure(input logic [63:0] tap, input int code, input bit ovf, input bit unf,
                         input int stall, input bit hold_chk, input bit arm_valid, input bit arm_accept);
    int n;
    bit got;
    dl_tap = tap;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back('{code: code, ovf: ovf, unf: unf});
    arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1 n++;
    end
    if (!got) begin
      check("valid_wait_expired", 64'd0, 64'd1);
      void'(sb.pop_back());
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      return;
    end
    check("latency", 64'(n), unf ? 64'(TIMEOUT + 1) : 64'd2);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1 arm = 1'b0;
      if (hold_chk) begin
        check("hold_valid", 64'(res_valid), 64'd1);
        check("hold_busy",  64'(busy),      64'd1);
        check("hold_code",  64'(res_code),  64'(code));
        check("hold_ovf",   64'(res_ovf),   64'(ovf));
        check("hold_unf",   64'(res_unf),   64'(unf));
      end
      if (arm_valid && s == 0) arm = 1'b1;
    end
    @(posedge clk);
    #1;
    arm       = arm_accept;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    arm       = 1'b0;
    check("valid_drop", 64'(res_valid), 64'd0);
    check("busy_drop",  64'(busy),      64'd0);
    if (arm_accept) begin
      repeat (2) begin
        @(posedge clk);
        #1 check("arm_in_accept_ignored", 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    logic [63:0] tap;
    int k;
    int kind;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    arm       = 1'b0;
    res_ready = 1'b0;
    dl_tap    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_code",  64'(res_code),  64'd0);
    check("rst_ovf",   64'(res_ovf),   64'd0);
    check("rst_unf",   64'(res_unf),   64'd0);
    rst_n = 1'b1;

    // Clean code, bubble, stray bit, overflow, timeout.
    measure(64'h0000_0000_0000_FFFF, 16, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    measure(64'h0000_0000_0000_F7FF, 16, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    measure(64'h0000_0000_0001_0FFF, 12, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    measure(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    measure(64'h0000_0000_0000_0000, 0,  1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);

    // Long stall with arm pulses in VALID and in the accept cycle.
    measure(64'h0000_0000_0000_003F, 6, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b1);

    // Reset mid-ARMED: outputs clear at once, no result follows.
    dl_tap = '0;
    repeat (3) @(posedge clk);
    #1 arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy",  64'(busy),      64'd0);
    check("abort_valid", 64'(res_valid), 64'd0);
    check("abort_code",  64'(res_code),  64'd0);
    check("abort_ovf",   64'(res_ovf),   64'd0);
    check("abort_unf",   64'(res_unf),   64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("post_abort_idle", 64'({busy, res_valid}), 64'd0);
    end

    // Random thermometer codes, optionally with an interior bubble or a
    // distant stray bit, neither of which changes the corrected count.
    for (int m = 0; m < 1000; m++) begin
      k    = int'($urandom_range(0, 64));
      kind = int'($urandom_range(0, 2));
      tap  = (k == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << k) - 64'd1);
      if (kind == 1 && k >= 4) tap[$urandom_range(1, k - 3)] = 1'b0;
      else if (kind == 2 && k >= 1 && k <= 61) tap[$urandom_range(k + 2, 63)] = 1'b1;
      measure(tap, k, (k == 64), (k == 0), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
